// File: rtl/spongent_inv_permute_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spongent_inv_permute_pkg                                               |
// | Shared constants, S-box tables, LFSR steps and FSM encoding.           |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package spongent_inv_permute_pkg;

  localparam int c_WIDTH  = 264;
  localparam int c_ROUNDS = 70;
  localparam int c_CW     = 8;
  localparam int c_NSBOX  = c_WIDTH / 4;

  localparam logic [3:0] c_SBOX_FWD [16] = '{
    4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
    4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
  };

  localparam logic [3:0] c_SBOX_INV [16] = '{
    4'h3, 4'h5, 4'h4, 4'hE, 4'h6, 4'hB, 4'hF, 4'h8,
    4'hA, 4'hC, 4'h9, 4'h2, 4'hD, 4'h1, 4'h0, 4'h7
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  function automatic logic [c_CW-1:0] lfsr_next(input logic [c_CW-1:0] x);
    return {x[6:0], x[7] ^ x[3] ^ x[2] ^ x[1]};
  endfunction

  // Exact inverse of lfsr_next; the feedback bit re-enters at the top.
  function automatic logic [c_CW-1:0] lfsr_prev(input logic [c_CW-1:0] y);
    return {y[0] ^ y[4] ^ y[3] ^ y[2], y[7:1]};
  endfunction

  function automatic logic [c_CW-1:0] bitrev(input logic [c_CW-1:0] x);
    logic [c_CW-1:0] r;
    r = '0;
    for (int i = 0; i < c_CW; i++) begin
      r[i] = x[c_CW-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spongent_inv_permute_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spongent_inv_permute_if                                                |
// | Request/result bundle between a requester and the inverse permutation. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface spongent_inv_permute_if #(
  parameter int WIDTH = 264
);
  logic             en;
  logic [WIDTH-1:0] state_in;
  logic [15:0]      IV_in;
  logic [WIDTH-1:0] state_out;
  logic [15:0]      IV_out;
  logic [15:0]      INV_IV_out;
  logic [7:0]       round_idx;
  logic             rdy;

  modport master (
    output en, state_in, IV_in,
    input  state_out, IV_out, INV_IV_out, round_idx, rdy
  );

  modport slave (
    input  en, state_in, IV_in,
    output state_out, IV_out, INV_IV_out, round_idx, rdy
  );
endinterface
`default_nettype wire

// File: rtl/spongent_inv_round.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spongent_inv_round                                                     |
// | One combinational inverse round: pLayer^-1, S-box^-1, counter XOR.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module spongent_inv_round
  import spongent_inv_permute_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [c_CW-1:0]  lc_i,
  output logic [WIDTH-1:0] state_o
);

  localparam int c_NSB = WIDTH / 4;

  logic [WIDTH-1:0] w_perm;
  logic [WIDTH-1:0] w_sub;

  // Forward pLayer sends bit j to j*WIDTH/4 mod (WIDTH-1); multiplying by 4 undoes it.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_pinv
    assign w_perm[(i * 4) % (WIDTH - 1)] = state_i[i];
  end
  assign w_perm[WIDTH-1] = state_i[WIDTH-1];

  for (genvar n = 0; n < c_NSB; n++) begin : g_sinv
    assign w_sub[4*n +: 4] = c_SBOX_INV[w_perm[4*n +: 4]];
  end

  assign state_o = w_sub ^ {bitrev(lc_i), {(WIDTH - 2*c_CW){1'b0}}, lc_i};

endmodule
`default_nettype wire

// File: rtl/spongent_inv_permute.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spongent_inv_permute                                                   |
// | Iterative inverse Spongent permutation, one inverse round per clock.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module spongent_inv_permute
  import spongent_inv_permute_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH,
  parameter int ROUNDS = c_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst,
  spongent_inv_permute_if.slave bus
);

  localparam logic [7:0] c_LAST = 8'(ROUNDS);

  fsm_e             fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [c_CW-1:0]  lc_q;
  logic [c_CW-1:0]  lc_d;
  logic [7:0]       round_q;
  logic [7:0]       round_d;
  logic             rdy_q;
  logic             w_unused_iv;

  spongent_inv_round #(
    .WIDTH (WIDTH)
  ) u_round (
    .state_i (state_q),
    .lc_i    (lc_q),
    .state_o (state_d)
  );

  assign lc_d        = lfsr_prev(lc_q);
  assign round_d     = round_q + 8'd1;
  assign w_unused_iv = ^bus.IV_in[15:c_CW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      lc_q    <= '0;
      round_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (bus.en) begin
            state_q <= bus.state_in;
            lc_q    <= bus.IV_in[c_CW-1:0];
            round_q <= '0;
            fsm_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort keeps the partial state visible; rdy never rises for it.
          if (!bus.en) begin
            fsm_q <= ST_IDLE;
          end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            round_q <= round_d;
            if (round_d == c_LAST) begin
              fsm_q <= ST_DONE;
              rdy_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!bus.en) begin
            rdy_q <= 1'b0;
            fsm_q <= ST_IDLE;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_out  = state_q;
  assign bus.IV_out     = {8'h00, lc_q};
  assign bus.INV_IV_out = {8'h00, bitrev(lc_q)};
  assign bus.round_idx  = round_q;
  assign bus.rdy        = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_spongent_inv_permute.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spongent_inv_permute                                                |
// | Round-trip checks against a forward Spongent model, scoreboard based.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_spongent_inv_permute;

  localparam int W  = 264;
  localparam int NS = W / 4;
  localparam int R  = 70;

  typedef struct {
    logic [W-1:0] st;
    logic [15:0]  iv;
    logic [15:0]  inv;
    logic [7:0]   ri;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] inv_tab [16];
  logic [3:0] fwd_tab [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spongent_inv_permute_if #(.WIDTH(W)) bus0 ();
  spongent_inv_permute_if #(.WIDTH(W)) bus1 ();

  spongent_inv_permute #(.WIDTH(W), .ROUNDS(R)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spongent_inv_permute #(.WIDTH(W), .ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [7:0] fwd_lfsr(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[3] ^ x[2] ^ x[1]};
  endfunction

  // Predecessor found by exhaustive search over the forward step.
  function automatic logic [7:0] back_lfsr(input logic [7:0] y);
    logic [7:0] r;
    r = 8'h00;
    for (int v = 0; v < 256; v++) begin
      if (fwd_lfsr(8'(v)) == y) r = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [7:0] step_n(input logic [7:0] x, input int n);
    logic [7:0] c;
    c = x;
    for (int i = 0; i < n; i++) c = fwd_lfsr(c);
    return c;
  endfunction

  function automatic logic [W-1:0] forward(input logic [W-1:0] x, input logic [7:0] iv, input int nr);
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [7:0]   c;
    s = x;
    c = iv;
    for (int r = 0; r < nr; r++) begin
      s[7:0]     = s[7:0] ^ c;
      s[W-1:W-8] = s[W-1:W-8] ^ rev8(c);
      for (int n = 0; n < NS; n++) s[4*n +: 4] = fwd_tab[s[4*n +: 4]];
      t[W-1] = s[W-1];
      for (int j = 0; j < W - 1; j++) t[(j * NS) % (W - 1)] = s[j];
      s = t;
      c = fwd_lfsr(c);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [287:0] t;
    for (int k = 0; k < 9; k++) t[32*k +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic compare_out(input string tag, input exp_t e, input logic [W-1:0] st,
                             input logic [15:0] iv, input logic [15:0] inv, input logic [7:0] ri);
    chk({tag, "_state"},   st,              e.st);
    chk({tag, "_iv"},      W'(iv),          W'(e.iv));
    chk({tag, "_inv_iv"},  W'(inv),         W'(e.inv));
    chk({tag, "_round"},   W'(ri),          W'(e.ri));
    chk({tag, "_latency"}, W'(cyc),         W'(e.due));
  endtask

  initial begin : mon0
    bit   p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.rdy === 1'b1 && !p) begin
        if (q0.size() == 0) begin
          total++;
          $display("FAIL dut0_unexpected_rdy: got rdy=1 required no pending result");
        end else begin
          e = q0.pop_front();
          compare_out("dut0", e, bus0.state_out, bus0.IV_out, bus0.INV_IV_out, bus0.round_idx);
        end
      end
      p = (bus0.rdy === 1'b1);
    end
  end

  initial begin : mon1
    bit   p;
    exp_t e;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (bus1.rdy === 1'b1 && !p) begin
        if (q1.size() == 0) begin
          total++;
          $display("FAIL dut1_unexpected_rdy: got rdy=1 required no pending result");
        end else begin
          e = q1.pop_front();
          compare_out("dut1", e, bus1.state_out, bus1.IV_out, bus1.INV_IV_out, bus1.round_idx);
        end
      end
      p = (bus1.rdy === 1'b1);
    end
  end

  function automatic logic rdy_of(input bit sel);
    return sel ? bus1.rdy : bus0.rdy;
  endfunction

  task automatic set_en(input bit sel, input logic v);
    if (sel) bus1.en = v;
    else     bus0.en = v;
  endtask

  task automatic start_raw(input bit sel, input logic [W-1:0] s, input logic [15:0] iv,
                           input exp_t ein, input bit push);
    exp_t e;
    e = ein;
    @(negedge clk);
    e.due = cyc + 1 + (sel ? 1 : R);
    if (push) begin
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
    end
    if (sel) begin bus1.state_in = s; bus1.IV_in = iv; bus1.en = 1'b1; end
    else     begin bus0.state_in = s; bus0.IV_in = iv; bus0.en = 1'b1; end
  endtask

  task automatic start_run(input bit sel, input logic [W-1:0] x, input logic [7:0] iv0, input bit push);
    exp_t       e;
    int         nr;
    logic [7:0] pv;
    nr    = sel ? 1 : R;
    pv    = back_lfsr(iv0);
    e.st  = x;
    e.iv  = {8'h00, pv};
    e.inv = {8'h00, rev8(pv)};
    e.ri  = 8'(nr);
    e.due = 0;
    start_raw(sel, forward(x, iv0, nr), {8'($urandom), step_n(iv0, nr - 1)}, e, push);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (rdy_of(sel) !== 1'b1 && n < R + 10) begin
      @(negedge clk);
      n++;
    end
    if (rdy_of(sel) !== 1'b1) begin
      total++;
      $display("FAIL rdy_timeout: got rdy=0 after %0d cycles required rdy=1", n);
    end
  endtask

  task automatic release_run(input bit sel);
    @(negedge clk);
    set_en(sel, 1'b0);
    @(negedge clk);
    chk("rdy_release", W'(rdy_of(sel)), W'(1'b0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin : main
    exp_t         e;
    logic [W-1:0] x;
    logic [7:0]   iv0;

    inv_tab = '{4'h3, 4'h5, 4'h4, 4'hE, 4'h6, 4'hB, 4'hF, 4'h8,
                4'hA, 4'hC, 4'h9, 4'h2, 4'hD, 4'h1, 4'h0, 4'h7};
    for (int i = 0; i < 16; i++) fwd_tab[inv_tab[i]] = 4'(i);

    bus0.en = 1'b0; bus0.state_in = '0; bus0.IV_in = '0;
    bus1.en = 1'b0; bus1.state_in = '0; bus1.IV_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", bus0.state_out, '0);
    chk("reset_iv",    W'(bus0.IV_out), '0);
    chk("reset_inv",   W'(bus0.INV_IV_out), '0);
    chk("reset_round", W'(bus0.round_idx), '0);
    chk("reset_rdy",   W'(bus0.rdy), '0);
    chk("reset_rdy1",  W'(bus1.rdy), '0);
    rst = 1'b0;

    // Single round from the all-zero state with counter 1.
    e.st  = {8'hB3, {62{4'h3}}, 8'h32};
    e.iv  = 16'h0080;
    e.inv = 16'h0001;
    e.ri  = 8'd1;
    e.due = 0;
    start_raw(1'b1, '0, 16'h0001, e, 1'b1);
    wait_done(1'b1);
    release_run(1'b1);

    // Round trip of bytes 0x00..0x20, then hold en high through DONE.
    for (int k = 0; k < 33; k++) x[8*k +: 8] = 8'(k);
    start_run(1'b0, x, 8'hC6, 1'b1);
    wait_done(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_rdy",   W'(bus0.rdy), W'(1'b1));
      chk("hold_state", bus0.state_out, x);
    end
    release_run(1'b0);

    for (int i = 0; i < 3; i++) begin
      start_run(1'b0, rand_state(), 8'($urandom), 1'b1);
      wait_done(1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_run(1'b0);
    end

    // Every counter value through the single-round instance.
    for (int v = 0; v < 256; v++) begin
      start_run(1'b1, rand_state(), 8'(v), 1'b1);
      wait_done(1'b1);
      release_run(1'b1);
    end

    // Abort at round 30, then reload.
    x   = rand_state();
    iv0 = 8'($urandom);
    start_run(1'b0, x, iv0, 1'b0);
    repeat (31) @(negedge clk);
    chk("abort_round_pre", W'(bus0.round_idx), W'(8'd30));
    set_en(1'b0, 1'b0);
    @(negedge clk);
    chk("abort_rdy",   W'(bus0.rdy), W'(1'b0));
    chk("abort_round", W'(bus0.round_idx), W'(8'd30));
    start_run(1'b0, x, iv0, 1'b1);
    wait_done(1'b0);
    release_run(1'b0);

    // Asynchronous reset between edges in the middle of a run.
    start_run(1'b0, rand_state(), 8'($urandom), 1'b1);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", bus0.state_out, '0);
    chk("arst_iv",    W'(bus0.IV_out), '0);
    chk("arst_inv",   W'(bus0.INV_IV_out), '0);
    chk("arst_round", W'(bus0.round_idx), '0);
    chk("arst_rdy",   W'(bus0.rdy), '0);
    set_en(1'b0, 1'b0);
    q0.delete();
    #1;
    rst = 1'b0;

    start_run(1'b0, rand_state(), 8'($urandom), 1'b1);
    wait_done(1'b0);
    release_run(1'b0);

    repeat (2) @(negedge clk);
    chk("q0_drained", W'(q0.size()), '0);
    chk("q1_drained", W'(q1.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
